// File: rtl/updown_timer_pkg.sv
// rtl/updown_timer_pkg.sv - shared run-control state encoding for updown_timer
package updown_timer_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RUN  = 2'd1;
  localparam logic [1:0] ENC_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_RUN  = ENC_RUN,
    ST_DONE = ENC_DONE
  } state_t;

endpackage

// File: rtl/updown_timer_if.sv
// rtl/updown_timer_if.sv - control and status bundle for updown_timer
interface updown_timer_if #(
  parameter int NBIT = 3
);

  logic            en;
  logic            dir;
  logic            load;
  logic [NBIT-1:0] load_val;
  logic            start;
  logic            stop;
  logic            periodic;
  logic [NBIT-1:0] q;
  logic            tc;
  logic            busy;
  logic            done;

  modport master (
    output en, dir, load, load_val, start, stop, periodic,
    input  q, tc, busy, done
  );

  modport slave (
    input  en, dir, load, load_val, start, stop, periodic,
    output q, tc, busy, done
  );

endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides qualified enable cycles into a one-cycle tick
module timer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/updown_timer.sv
// rtl/updown_timer.sv - programmable up/down counter-timer with load/reload and run control
// Optional prescaler enabled by defining UPDOWN_TIMER_PRESCALE_EN.
module updown_timer
  import updown_timer_pkg::*;
#(
  parameter int NBIT = 3
`ifdef UPDOWN_TIMER_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  updown_timer_if.slave bus
);

  localparam logic [NBIT-1:0] ONE = NBIT'(1);

  state_t          state;
  state_t          state_nxt;
  logic [NBIT-1:0] q;
  logic [NBIT-1:0] q_nxt;
  logic [NBIT-1:0] reload;
  logic [NBIT-1:0] reload_nxt;
  logic            tc;
  logic            tc_nxt;
  logic            busy;
  logic            done;
  logic            at_term;
  logic            count_tick;

`ifdef UPDOWN_TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (bus.load | bus.stop | bus.start),
    .en  (bus.en && (state == ST_RUN)),
    .tick(count_tick)
  );
`else
  assign count_tick = bus.en;
`endif

  // Terminal follows the direction sampled this cycle, so a mid-run dir change retargets it.
  assign at_term = bus.dir ? (q == '0) : (q == '1);

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload;
    tc_nxt     = 1'b0;
    if (bus.load) begin
      q_nxt      = bus.load_val;
      reload_nxt = bus.load_val;
      if (state == ST_DONE) begin
        state_nxt = ST_IDLE;
      end
    end else if (bus.stop) begin
      if (state == ST_RUN) begin
        state_nxt = ST_IDLE;
      end
    end else if (bus.start) begin
      if (state != ST_RUN) begin
        state_nxt = ST_RUN;
      end
    end else if ((state == ST_RUN) && count_tick) begin
      if (at_term) begin
        tc_nxt = 1'b1;
        if (bus.periodic) begin
          q_nxt = reload;
        end else begin
          state_nxt = ST_DONE;
        end
      end else begin
        q_nxt = bus.dir ? (q - ONE) : (q + ONE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      q      <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      reload <= reload_nxt;
      tc     <= tc_nxt;
      busy   <= (state_nxt == ST_RUN);
      done   <= (state_nxt == ST_DONE);
    end
  end

  assign bus.q    = q;
  assign bus.tc   = tc;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule
